// File: rtl/fb_pkg.sv
// Frame-buffer constants and types shared by the write engine and the scan-out side.
package fb_pkg;

    localparam int FB_WIDTH  = 480;
    localparam int FB_HEIGHT = 360;
    localparam int FB_PIXELS = FB_WIDTH * FB_HEIGHT;
    localparam int FB_ADDR_W = 18;

    localparam int CMD_W = 10;
    localparam int END_W = CMD_W + 1;

    typedef logic [7:0] color_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } wr_state_t;

    // Start-of-row address; the only multiply in the write path, used once per command.
    function automatic logic [FB_ADDR_W-1:0] row_offset(input logic [CMD_W-1:0] y);
        return FB_ADDR_W'(y) * FB_ADDR_W'(FB_WIDTH);
    endfunction

endpackage

// File: rtl/fb_rect_writer_if.sv
// Command handshake and frame-buffer write port of the rectangle writer.
interface fb_rect_writer_if;
    import fb_pkg::*;

    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [CMD_W-1:0]     cmd_x;
    logic [CMD_W-1:0]     cmd_y;
    logic [CMD_W-1:0]     cmd_w;
    logic [CMD_W-1:0]     cmd_h;
    color_t               cmd_color;
    logic                 fb_grant;
    logic                 fb_we;
    logic [FB_ADDR_W-1:0] fb_addr;
    color_t               fb_data_in;
    logic                 busy;
    logic                 done;

    // Command source / arbiter side.
    modport master (
        output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, fb_grant,
        input  cmd_ready, fb_we, fb_addr, fb_data_in, busy, done
    );

    // Write engine side.
    modport slave (
        input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, fb_grant,
        output cmd_ready, fb_we, fb_addr, fb_data_in, busy, done
    );

endinterface

// File: rtl/fb_rect_clip.sv
// Clips a rectangle to the frame: exclusive end column/row and an empty flag.
module fb_rect_clip
    import fb_pkg::*;
(
    input  logic [CMD_W-1:0] x,
    input  logic [CMD_W-1:0] y,
    input  logic [CMD_W-1:0] w,
    input  logic [CMD_W-1:0] h,
    output logic [END_W-1:0] x_end,
    output logic [END_W-1:0] y_end,
    output logic             empty
);

    logic [END_W-1:0] x_sum;
    logic [END_W-1:0] y_sum;

    // One extra bit on the sums so x+w / y+h never wrap before the clamp.
    always_comb begin
        x_sum = {1'b0, x} + {1'b0, w};
        y_sum = {1'b0, y} + {1'b0, h};
        x_end = (x_sum > END_W'(FB_WIDTH))  ? END_W'(FB_WIDTH)  : x_sum;
        y_end = (y_sum > END_W'(FB_HEIGHT)) ? END_W'(FB_HEIGHT) : y_sum;
        empty = (w == '0) || (h == '0) ||
                (x >= CMD_W'(FB_WIDTH)) || (y >= CMD_W'(FB_HEIGHT));
    end

endmodule

// File: rtl/fb_rect_writer.sv
// Rectangle-fill engine: accepts a command, clips it, writes pixels row-major when granted.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// SETUP | one cycle: clip result used, row base and first address loaded
// WRITE | one pixel per granted cycle, row-major
// DONE  | one cycle: done pulse, then back to IDLE
module fb_rect_writer
    import fb_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    fb_rect_writer_if.slave  bus
);

    wr_state_t            state;
    wr_state_t            state_nxt;

    logic [CMD_W-1:0]     lat_x;
    logic [CMD_W-1:0]     lat_y;
    logic [CMD_W-1:0]     lat_w;
    logic [CMD_W-1:0]     lat_h;
    color_t               lat_color;

    logic [CMD_W-1:0]     cur_x;
    logic [CMD_W-1:0]     cur_y;
    logic [FB_ADDR_W-1:0] row_base;
    logic [FB_ADDR_W-1:0] addr_q;

    logic [END_W-1:0]     x_end;
    logic [END_W-1:0]     y_end;
    logic                 empty;

    logic                 accept;
    logic                 granted;
    logic                 col_last;
    logic                 row_last;
    logic [FB_ADDR_W-1:0] setup_base;
    logic [FB_ADDR_W-1:0] next_base;

    fb_rect_clip u_clip (
        .x     (lat_x),
        .y     (lat_y),
        .w     (lat_w),
        .h     (lat_h),
        .x_end (x_end),
        .y_end (y_end),
        .empty (empty)
    );

    assign accept     = bus.cmd_valid && (state == IDLE);
    assign granted    = (state == WRITE) && bus.fb_grant;
    assign col_last   = (({1'b0, cur_x} + END_W'(1)) == x_end);
    assign row_last   = (({1'b0, cur_y} + END_W'(1)) == y_end);
    assign setup_base = row_offset(lat_y);
    assign next_base  = row_base + FB_ADDR_W'(FB_WIDTH);

    // State register.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SETUP;
            SETUP:   state_nxt = empty ? DONE : WRITE;
            WRITE:   if (granted && col_last && row_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake and strobe outputs; the write strobe follows the grant combinationally.
    always_comb begin
        bus.cmd_ready = (state == IDLE);
        bus.busy      = (state != IDLE);
        bus.done      = (state == DONE);
        bus.fb_we     = granted;
    end

    assign bus.fb_addr    = addr_q;
    assign bus.fb_data_in = lat_color;

    // Command latch and pixel walker; row step is an add of FB_WIDTH, never a multiply.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            lat_x     <= '0;
            lat_y     <= '0;
            lat_w     <= '0;
            lat_h     <= '0;
            lat_color <= '0;
            cur_x     <= '0;
            cur_y     <= '0;
            row_base  <= '0;
            addr_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat_x     <= bus.cmd_x;
                        lat_y     <= bus.cmd_y;
                        lat_w     <= bus.cmd_w;
                        lat_h     <= bus.cmd_h;
                        lat_color <= bus.cmd_color;
                    end
                end
                SETUP: begin
                    if (!empty) begin
                        row_base <= setup_base;
                        cur_x    <= lat_x;
                        cur_y    <= lat_y;
                        addr_q   <= setup_base + FB_ADDR_W'(lat_x);
                    end
                end
                WRITE: begin
                    // The last pixel leaves the address on itself so it never points past the frame.
                    if (granted && !(col_last && row_last)) begin
                        if (col_last) begin
                            cur_x    <= lat_x;
                            cur_y    <= cur_y + CMD_W'(1);
                            row_base <= next_base;
                            addr_q   <= next_base + FB_ADDR_W'(lat_x);
                        end else begin
                            cur_x    <= cur_x + CMD_W'(1);
                            addr_q   <= addr_q + FB_ADDR_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fb_rect_writer.sv
// Self-checking bench for fb_rect_writer: directed table, random commands, reset mid-fill.
module tb_fb_rect_writer;
    import fb_pkg::*;

    logic Clk   = 1'b0;
    logic Reset = 1'b0;

    fb_rect_writer_if bus();

    fb_rect_writer dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];

    typedef struct {
        int x;
        int y;
        int w;
        int h;
        int color;
        int mode;       // 0 continuous grant, 1 one stall window, 2 random grant + noise on cmd
        int stall_at;
        int stall_len;
        int exp_n;
        int exp_done;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: every pixel inside the rectangle and the frame, in row-major order.
    task automatic build_model(input int x, input int y, input int w, input int h);
        exp_q.delete();
        for (int yy = y; yy < y + h; yy++) begin
            for (int xx = x; xx < x + w; xx++) begin
                if (xx < FB_WIDTH && yy < FB_HEIGHT)
                    exp_q.push_back(yy * FB_WIDTH + xx);
            end
        end
    endtask

    task automatic drive_quiet();
        bus.cmd_valid = 1'b0;
        bus.cmd_x     = '0;
        bus.cmd_y     = '0;
        bus.cmd_w     = '0;
        bus.cmd_h     = '0;
        bus.cmd_color = '0;
        bus.fb_grant  = 1'b0;
    endtask

    // One command from accept to done; k counts cycles after the accepting edge.
    task automatic run_cmd(input int x, input int y, input int w, input int h, input int color,
                           input int mode, input int stall_at, input int stall_len,
                           output int act_n, output int act_done);
        int  n;
        int  k;
        int  mwr;
        int  exp_done;
        int  lim;
        bit  g;
        bit  exp_we;

        build_model(x, y, w, h);
        n        = exp_q.size();
        exp_done = (n == 0) ? 2 : -1;
        lim      = n * 16 + stall_len + 40;
        act_n    = 0;
        act_done = -1;
        mwr      = 0;

        @(negedge Clk);
        bus.cmd_x     = CMD_W'(x);
        bus.cmd_y     = CMD_W'(y);
        bus.cmd_w     = CMD_W'(w);
        bus.cmd_h     = CMD_W'(h);
        bus.cmd_color = color_t'(color);
        bus.cmd_valid = 1'b1;
        bus.fb_grant  = 1'b1;
        #1;
        chk("cmd_ready_idle", bus.cmd_ready, 1);
        chk("busy_idle", bus.busy, 0);
        chk("done_idle", bus.done, 0);
        chk("fb_we_idle", bus.fb_we, 0);

        k = 0;
        forever begin
            @(negedge Clk);
            k++;
            case (mode)
                0:       g = 1'b1;
                1:       g = !(k >= stall_at && k < stall_at + stall_len);
                default: g = ($urandom_range(3) != 0);
            endcase
            bus.fb_grant = g;
            if (mode == 2) begin
                bus.cmd_valid = 1'($urandom_range(1));
                bus.cmd_x     = CMD_W'($urandom);
                bus.cmd_y     = CMD_W'($urandom);
                bus.cmd_w     = CMD_W'($urandom);
                bus.cmd_h     = CMD_W'($urandom);
                bus.cmd_color = color_t'($urandom);
            end else begin
                bus.cmd_valid = 1'b0;
            end
            #1;
            exp_we = (k >= 2) && (mwr < n) && g;
            chk("fb_we", bus.fb_we, exp_we);
            if (k >= 2 && mwr < n)
                chk("fb_addr", bus.fb_addr, exp_q[mwr]);
            if (bus.fb_we) begin
                act_n++;
                chk("fb_data", bus.fb_data_in, color);
                chk("addr_in_frame", bus.fb_addr < FB_PIXELS, 1);
            end
            if (exp_we) begin
                mwr++;
                if (mwr == n) exp_done = k + 1;
            end
            chk("done", bus.done, k == exp_done);
            chk("cmd_ready_busy", bus.cmd_ready, 0);
            chk("busy", bus.busy, 1);
            if (bus.done && act_done < 0) act_done = k;
            if (k == exp_done) break;
            if (k >= lim) begin
                n_checks++;
                n_fail++;
                $display("FAIL cycle_budget: no done after %0d cycles, expected by %0d", k, exp_done);
                break;
            end
        end
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        int act_n;
        int act_done;
        int wcnt;
        int rx, ry, rw, rh, rc;

        tbl[0] = '{10,  5,   2,   2,   'h3C, 0, 0, 0, 4,     6};
        tbl[1] = '{478, 359, 5,   3,   'hA5, 0, 0, 0, 2,     4};
        tbl[2] = '{0,   0,   3,   1,   'h5A, 1, 3, 3, 3,     8};
        tbl[3] = '{7,   9,   0,   4,   'h11, 0, 0, 0, 0,     2};
        tbl[4] = '{480, 10,  5,   5,   'h22, 0, 0, 0, 0,     2};
        tbl[5] = '{100, 360, 4,   4,   'h33, 0, 0, 0, 0,     2};
        tbl[6] = '{475, 0,   10,  2,   'h44, 0, 0, 0, 10,    12};
        tbl[7] = '{3,   357, 2,   10,  'h55, 0, 0, 0, 6,     8};
        tbl[8] = '{0,   260, 480, 200, 'h00, 0, 0, 0, 48000, 48002};

        drive_quiet();
        Reset = 1'b0;
        repeat (3) @(negedge Clk);
        #1;
        chk("rst_fb_we", bus.fb_we, 0);
        chk("rst_fb_addr", bus.fb_addr, 0);
        chk("rst_fb_data", bus.fb_data_in, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        Reset = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_cmd(tbl[i].x, tbl[i].y, tbl[i].w, tbl[i].h, tbl[i].color,
                    tbl[i].mode, tbl[i].stall_at, tbl[i].stall_len, act_n, act_done);
            chk("vec_writes", act_n, tbl[i].exp_n);
            chk("vec_done_cycle", act_done, tbl[i].exp_done);
        end

        for (int i = 0; i < 12; i++) begin
            rx = $urandom_range(500);
            ry = $urandom_range(380);
            rw = $urandom_range(40);
            rh = $urandom_range(20);
            rc = $urandom_range(255);
            run_cmd(rx, ry, rw, rh, rc, 2, 0, 0, act_n, act_done);
            build_model(rx, ry, rw, rh);
            chk("rand_writes", act_n, exp_q.size());
        end

        // Reset in the middle of a 10x10 fill, after seven writes.
        @(negedge Clk);
        bus.cmd_x     = 10'd20;
        bus.cmd_y     = 10'd20;
        bus.cmd_w     = 10'd10;
        bus.cmd_h     = 10'd10;
        bus.cmd_color = 8'h77;
        bus.cmd_valid = 1'b1;
        bus.fb_grant  = 1'b1;
        #1;
        chk("mid_cmd_ready", bus.cmd_ready, 1);
        wcnt = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge Clk);
            bus.cmd_valid = 1'b0;
            #1;
            if (bus.fb_we) wcnt++;
        end
        chk("mid_writes_before_reset", wcnt, 7);
        Reset = 1'b0;
        @(negedge Clk);
        #1;
        chk("mid_rst_fb_we", bus.fb_we, 0);
        chk("mid_rst_done", bus.done, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_fb_addr", bus.fb_addr, 0);
        chk("mid_rst_fb_data", bus.fb_data_in, 0);
        @(negedge Clk);
        Reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge Clk);
            #1;
            chk("post_rst_done", bus.done, 0);
            chk("post_rst_fb_we", bus.fb_we, 0);
            chk("post_rst_cmd_ready", bus.cmd_ready, 1);
        end
        run_cmd(1, 1, 3, 2, 'h9E, 0, 0, 0, act_n, act_done);
        chk("post_rst_writes", act_n, 6);
        chk("post_rst_done_cycle", act_done, 8);

        @(negedge Clk);
        #1;
        chk("final_done_low", bus.done, 0);
        chk("final_cmd_ready", bus.cmd_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
